cp0: RTL and testbench

Coprocessor 0 for the exception-capable MIPS pipeline, located in the MEM stage. It holds SR, Cause, EPC and PRId, and executes mtc0 writes. It decides each cycle whether the instruction in MEM must be squashed for an interrupt or exception and drives `req`. `req` and the mfc0 read data (`cp0Out`) go to the MEM-stage write-back selector. On `req`, that selector suppresses the register write and the pipeline redirects to the handler.

---
 rtl/cp0_pkg.sv | 55 +++++
 rtl/cp0.sv | 100 ++++++++++
 tb/tb_cp0.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared definitions for coprocessor 0: register numbers, bit-field positions,
// exception codes and the packing helpers used to present SR and Cause.
package cp0_pkg;

  localparam logic [4:0] SR_NUM    = 5'd12;
  localparam logic [4:0] CAUSE_NUM = 5'd13;
  localparam logic [4:0] EPC_NUM   = 5'd14;
  localparam logic [4:0] PRID_NUM  = 5'd15;

  localparam int IM_HI      = 15;
  localparam int IM_LO      = 10;
  localparam int IP_HI      = 15;
  localparam int IP_LO      = 10;
  localparam int EXL_BIT    = 1;
  localparam int IE_BIT     = 0;
  localparam int BD_BIT     = 31;
  localparam int EXCCODE_HI = 6;
  localparam int EXCCODE_LO = 2;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] w;
    w = '0;
    w[IM_HI:IM_LO] = im;
    w[EXL_BIT]     = exl;
    w[IE_BIT]      = ie;
    return w;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc_code);
    logic [31:0] w;
    w = '0;
    w[BD_BIT]                = bd;
    w[IP_HI:IP_LO]           = ip;
    w[EXCCODE_HI:EXCCODE_LO] = exc_code;
    return w;
  endfunction

  // A delay-slot instruction restarts at its branch, so EPC backs up one word.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    logic [31:0] w_sel;
    w_sel = bd ? (pc - 32'd4) : pc;
    return {w_sel[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0.sv
// Coprocessor 0 in the MEM stage: SR/Cause/EPC/PRId, mtc0 writes, mfc0 reads
// and the combinational squash/redirect request for interrupts and exceptions.
module cp0 import cp0_pkg::*; #(
  parameter logic [31:0] PRID       = 32'h2023_0701,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        we,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic [31:0] cp0Out,
  output logic [31:0] EPCOut,
  output logic        req
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_read;

  // The handler address is consumed by fetch; the parameter lives here so it
  // travels with the rest of the exception configuration.
  logic [31:0] w_unused_handler;
  assign w_unused_handler = HANDLER_PC;

  // Interrupts sample the live lines, not the registered Cause.IP copy.
  assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
  assign w_req     = w_int_req | w_exc_req;
  assign req       = w_req;

  assign w_sr    = pack_sr(r_im, r_exl, r_ie);
  assign w_cause = pack_cause(r_bd, r_ip, r_exccode);

  always_comb begin
    w_read = '0;
    case (A1)
      SR_NUM:    w_read = w_sr;
      CAUSE_NUM: w_read = w_cause;
      EPC_NUM:   w_read = r_epc;
      PRID_NUM:  w_read = PRID;
      default:   w_read = '0;
    endcase
  end

  assign cp0Out = w_read;
  assign EPCOut = r_epc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= HWInt;
      if (w_req) begin
        // Taking the trap squashes the MEM instruction, including any mtc0/eret.
        r_exl     <= 1'b1;
        r_exccode <= w_int_req ? EXC_INT : ExcCodeIn;
        r_bd      <= BDIn;
        r_epc     <= epc_of(PC, BDIn);
      end else begin
        if (we && (A2 == SR_NUM)) begin
          r_im  <= DIn[IM_HI:IM_LO];
          r_exl <= DIn[EXL_BIT];
          r_ie  <= DIn[IE_BIT];
        end
        if (we && (A2 == EPC_NUM)) begin
          r_epc <= {DIn[31:2], 2'b00};
        end
        // Placed after the SR write so an eret beats a same-cycle mtc0 on EXL.
        if (EXLClr) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
// Bench for cp0: directed scenarios with fixed expectations, then randomized
// traffic checked against a word-level model of the coprocessor registers.
module tb_cp0;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic        we;
  logic [31:0] PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic        EXLClr;
  logic [5:0]  HWInt;
  wire  [31:0] cp0Out;
  wire  [31:0] EPCOut;
  wire         req;

  localparam logic [31:0] PRID_V  = 32'h2023_0701;
  localparam logic [31:0] SR_MASK = 32'h0000_FC03;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_sr, m_cause, m_epc;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cp0 dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .we(we), .PC(PC),
    .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .EXLClr(EXLClr), .HWInt(HWInt),
    .cp0Out(cp0Out), .EPCOut(EPCOut), .req(req)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: registers are plain 32-bit words, request rules taken literally.
  function automatic logic m_int();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_V;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_update();
    logic        r, i;
    logic [31:0] ip_word;
    r = m_req();
    i = m_int();
    ip_word = {26'd0, HWInt} << 10;
    if (!reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else if (r) begin
      m_sr    = m_sr | 32'h2;
      m_cause = ({31'd0, BDIn} << 31) | ip_word | ((i ? 32'd0 : {27'd0, ExcCodeIn}) << 2);
      m_epc   = (BDIn ? PC - 32'd4 : PC) & ~32'h3;
    end else begin
      if (we && A2 == 5'd12) m_sr = DIn & SR_MASK;
      if (we && A2 == 5'd14) m_epc = DIn & ~32'h3;
      if (EXLClr) m_sr = m_sr & ~32'h2;
      m_cause = (m_cause & ~32'h0000_FC00) | ip_word;
    end
  endtask

  // Mid-cycle: compare the combinational outputs against the model.
  task automatic mid();
    @(negedge clk);
    exp_q.push_back(m_read(A1));
    chk("req", {31'd0, req}, {31'd0, m_req()});
    chk("cp0Out", cp0Out, exp_q.pop_front());
    chk("EPCOut", EPCOut, m_epc);
  endtask

  task automatic fin();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle();
    we = 0; A2 = 0; DIn = 0; PC = 0; BDIn = 0; ExcCodeIn = 0; EXLClr = 0;
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    A1 = a;
    mid();
    chk(tag, cp0Out, exp);
    fin();
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 0; A1 = 0; HWInt = 0;
    idle();
    #1;
    fin();
    reset = 1;

    // Reset state
    rd(5'd12, "rst_sr", 32'd0);
    rd(5'd13, "rst_cause", 32'd0);
    rd(5'd14, "rst_epc", 32'd0);
    A1 = 5'd15; mid(); chk("rst_prid", cp0Out, PRID_V); chk("rst_req", {31'd0, req}, 32'd0); fin();

    // Enabled interrupt
    we = 1; A2 = 5'd12; DIn = 32'h0000_0401; mid(); fin(); idle();
    HWInt = 6'b000001; PC = 32'h3010;
    mid(); chk("int_req", {31'd0, req}, 32'd1); fin();
    PC = 0;
    mid(); chk("int_req_drop", {31'd0, req}, 32'd0); fin();
    rd(5'd12, "int_sr", 32'h0000_0403);
    rd(5'd13, "int_cause", 32'h0000_0400);
    rd(5'd14, "int_epc", 32'h0000_3010);

    // Delay-slot exception
    HWInt = 0; EXLClr = 1; mid(); fin(); idle();
    ExcCodeIn = 5'd12; BDIn = 1; PC = 32'h3024;
    mid(); chk("ds_req", {31'd0, req}, 32'd1); fin(); idle();
    rd(5'd13, "ds_cause", 32'h8000_0030);
    chk("ds_epcout", EPCOut, 32'h0000_3020);

    // Interrupt beats exception
    EXLClr = 1; mid(); fin(); idle();
    HWInt = 6'b000001; ExcCodeIn = 5'd10; PC = 32'h3100;
    mid(); chk("prio_req", {31'd0, req}, 32'd1); fin(); idle();
    rd(5'd13, "prio_cause", 32'h0000_0400);

    // EXL masks exceptions
    ExcCodeIn = 5'd4; PC = 32'h3200;
    mid(); chk("exl_req", {31'd0, req}, 32'd0); fin(); idle();
    rd(5'd14, "exl_epc", 32'h0000_3100);
    rd(5'd13, "exl_cause", 32'h0000_0400);

    // IE=0 masks interrupts but IP still tracks the lines
    HWInt = 0; EXLClr = 1; mid(); fin(); idle();
    we = 1; A2 = 5'd12; DIn = 32'h0000_0400; mid(); fin(); idle();
    HWInt = 6'b100001;
    mid(); chk("ie0_req", {31'd0, req}, 32'd0); fin();
    rd(5'd13, "ie0_cause", 32'h0000_8400);

    // eret vs mtc0 SR in the same cycle
    HWInt = 0;
    we = 1; A2 = 5'd12; DIn = 32'h0000_0403; mid(); fin();
    EXLClr = 1; mid(); fin(); idle();
    rd(5'd12, "race_sr", 32'h0000_0401);

    // mtc0 squashed by an exception
    ExcCodeIn = 5'd5; we = 1; A2 = 5'd14; DIn = 32'hDEAD_BEEF; PC = 32'h3300;
    mid(); chk("sq_req", {31'd0, req}, 32'd1); fin(); idle();
    rd(5'd14, "sq_epc", 32'h0000_3300);
    rd(5'd13, "sq_cause", 32'h0000_0014);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      reset     = ($urandom_range(0, 49) != 0);
      we        = ($urandom_range(0, 2) == 0);
      A2        = 5'($urandom_range(10, 16));
      A1        = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(11, 16));
      DIn       = $urandom;
      PC        = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      BDIn      = 1'($urandom);
      ExcCodeIn = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      EXLClr    = ($urandom_range(0, 5) == 0);
      HWInt     = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      mid();
      fin();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
